if_stage: RTL and testbench

- Fetch-stage pipeline register and consumer of the PC handshake in the 5-stage RV32I pipelined core.
- Accepts the next PC from the pre-IF/PC logic when `pre_if_valid` and `if_allow_in` are both 1.
- Issues the synchronous instruction-memory read and holds the returned instruction across ID back-pressure.
- Presents {pc, inst, exception} to ID with a valid/allow-in handshake.

---
 rtl/pipeline_defs.sv | 23 ++
 rtl/if_inst_hold.sv | 61 ++++++
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Core-wide constants shared by the RV32I pipeline stages and the CSR/exception unit.
package pipeline_defs;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [3:0] {
    EXC_INST_MISALIGN = 4'd0,
    EXC_INST_ACCESS   = 4'd1,
    EXC_ILLEGAL_INST  = 4'd2,
    EXC_BREAKPOINT    = 4'd3,
    EXC_LOAD_MISALIGN = 4'd4,
    EXC_LOAD_ACCESS   = 4'd5,
    EXC_STORE_MISALIGN= 4'd6,
    EXC_STORE_ACCESS  = 4'd7,
    EXC_ECALL_M       = 4'd11
  } excp_cause_e;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_inst_hold.sv
// Captures the synchronous imem read data and holds it stable while ID stalls.
module if_inst_hold
  import pipeline_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        accept,
  input  logic        fetch,
  input  logic        id_allow_in,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst
);

  logic        fresh_r;
  logic        buf_valid_r;
  logic [31:0] inst_buf_r;

  // fresh marks the single cycle in which imem_rdata belongs to the held entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fresh_r <= 1'b0;
    end else if (flush) begin
      fresh_r <= 1'b0;
    end else if (accept) begin
      fresh_r <= fetch;
    end else begin
      fresh_r <= 1'b0;
    end
  end

  // capture read data when ID is not ready in the fresh cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
      inst_buf_r  <= NOP_INST;
    end else if (flush || accept) begin
      buf_valid_r <= 1'b0;
    end else if (fresh_r && !id_allow_in) begin
      buf_valid_r <= 1'b1;
      inst_buf_r  <= imem_rdata;
    end else if (id_allow_in) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // a non-fresh, non-buffered entry is a misaligned fetch that never read memory
  always_comb begin
    inst = NOP_INST;
    if (fresh_r) begin
      inst = imem_rdata;
    end else if (buf_valid_r) begin
      inst = inst_buf_r;
    end else begin
      inst = NOP_INST;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC handshake with pre-IF, imem request, and valid/allow-in handshake to ID.
module if_stage
  import pipeline_defs::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pre_if_valid,
  input  logic [XLEN-1:0] pc_next,
  output logic            if_allow_in,
  input  logic            flush,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            id_allow_in,
  output logic            if_to_id_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_excp_misalign
);

  logic            if_valid_r;
  logic [XLEN-1:0] if_pc_r;
  logic            misalign_r;
  logic            accept_s;
  logic            next_misalign_s;

  assign next_misalign_s = pc_misaligned(pc_next);

  // accept is held off during reset so no read is issued before the pipe is clean
  always_comb begin
    if_allow_in    = !if_valid_r || id_allow_in;
    accept_s       = rst_n && pre_if_valid && if_allow_in && !flush;
    imem_en        = accept_s && !next_misalign_s;
    imem_addr      = pc_next;
    if_to_id_valid = if_valid_r && !flush;
  end

  // entry valid: flush wins, then a new accept, then a leave to ID
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
    end else if (flush) begin
      if_valid_r <= 1'b0;
    end else if (accept_s) begin
      if_valid_r <= 1'b1;
    end else if (id_allow_in) begin
      if_valid_r <= 1'b0;
    end else begin
      if_valid_r <= if_valid_r;
    end
  end

  // PC register and its fetch-fault flag load together on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_pc_r    <= {XLEN{1'b0}};
      misalign_r <= 1'b0;
    end else if (accept_s) begin
      if_pc_r    <= pc_next;
      misalign_r <= next_misalign_s;
    end else begin
      if_pc_r    <= if_pc_r;
      misalign_r <= misalign_r;
    end
  end

  assign if_pc            = if_pc_r;
  assign if_excp_misalign = misalign_r;

  if_inst_hold u_inst_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .accept      (accept_s),
    .fetch       (imem_en),
    .id_allow_in (id_allow_in),
    .imem_rdata  (imem_rdata),
    .inst        (if_inst)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected {pc,inst,misalign} per ID handoff.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pre_if_valid = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        if_allow_in;
  logic        flush = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_allow_in = 1'b1;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_excp_misalign;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre_if_valid     (pre_if_valid),
    .pc_next          (pc_next),
    .if_allow_in      (if_allow_in),
    .flush            (flush),
    .imem_en          (imem_en),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .id_allow_in      (id_allow_in),
    .if_to_id_valid   (if_to_id_valid),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_excp_misalign (if_excp_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return 32'h0000_00A0 + a;
  endfunction

  // synchronous memory: garbage on cycles without a read
  always @(posedge clk) imem_rdata <= imem_en ? mem_word(imem_addr) : JUNK;

  // scoreboard: compare every instruction handed to ID
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_to_id_valid === 1'b1 && id_allow_in === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got pc=%h inst=%h, required no handoff", if_pc, if_inst);
      end else begin
        e = sb_q.pop_front();
        if ({if_pc, if_inst, if_excp_misalign} !== {e.pc, e.inst, e.mis}) begin
          errors++;
          $display("FAIL handoff: got pc=%h inst=%h mis=%b, required pc=%h inst=%h mis=%b",
                   if_pc, if_inst, if_excp_misalign, e.pc, e.inst, e.mis);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pre_if_valid = 1'b1; pc_next = 32'h0; id_allow_in = 1'b1;
    tick(); tick(); settle();
    checks++;
    if ({if_to_id_valid, imem_en} !== 2'b00) begin
      errors++; $display("FAIL reset_outputs: got valid/en=%b, required 00", {if_to_id_valid, imem_en});
    end
    rst_n = 1'b1; settle();
    checks++;
    if ({if_allow_in, imem_en} !== 2'b11 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got allow/en=%b addr=%h, required 11 addr=0", {if_allow_in, imem_en}, imem_addr);
    end
    sb_q.push_back('{pc: 32'h0, inst: mem_word(32'h0), mis: 1'b0});
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_to_id_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL reset_first_out: got valid=%b pc=%h, required 1 pc=0", if_to_id_valid, if_pc);
    end
    tick();
  endtask

  task automatic test_streaming();
    id_allow_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      pre_if_valid = 1'b1; pc_next = 32'(4 * i);
      sb_q.push_back('{pc: 32'(4 * i), inst: mem_word(32'(4 * i)), mis: 1'b0});
      settle();
      checks++;
      if (imem_en !== 1'b1 || (i > 0 && if_to_id_valid !== 1'b1)) begin
        errors++; $display("FAIL stream_cycle%0d: got en=%b valid=%b, required 1 1", i, imem_en, if_to_id_valid);
      end
    end
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_to_id_valid !== 1'b1 || if_pc !== 32'hC) begin
      errors++; $display("FAIL stream_last: got valid=%b pc=%h, required 1 pc=c", if_to_id_valid, if_pc);
    end
    tick(); settle();
    checks++;
    if (if_to_id_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got valid=%b, required 0", if_to_id_valid);
    end
  endtask

  task automatic test_stall_hold();
    tick();
    pre_if_valid = 1'b1; pc_next = 32'h10; id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h10, inst: 32'h0050_0093, mis: 1'b0});
    for (int k = 0; k < 3; k++) begin
      tick();
      id_allow_in = 1'b0; pre_if_valid = 1'b1; pc_next = 32'h14;
      settle();
      checks++;
      if (if_inst !== 32'h0050_0093 || if_allow_in !== 1'b0 || imem_en !== 1'b0 || if_to_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got inst=%h allow=%b en=%b valid=%b, required 00500093 0 0 1",
                           k, if_inst, if_allow_in, imem_en, if_to_id_valid);
      end
    end
    tick();
    id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h14, inst: mem_word(32'h14), mis: 1'b0});
    settle();
    checks++;
    if (if_inst !== 32'h0050_0093 || imem_en !== 1'b1) begin
      errors++; $display("FAIL stall_release: got inst=%h en=%b, required 00500093 1", if_inst, imem_en);
    end
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_pc !== 32'h14 || if_to_id_valid !== 1'b1) begin
      errors++; $display("FAIL stall_next: got pc=%h valid=%b, required 14 1", if_pc, if_to_id_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    tick();
    pre_if_valid = 1'b1; pc_next = 32'h20; id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h20, inst: mem_word(32'h20), mis: 1'b0});
    tick(); pre_if_valid = 1'b0; id_allow_in = 1'b0;
    tick();
    flush = 1'b1; pre_if_valid = 1'b1; pc_next = 32'h80; id_allow_in = 1'b1;
    void'(sb_q.pop_front());
    settle();
    checks++;
    if (if_to_id_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: got valid=%b en=%b, required 0 0", if_to_id_valid, imem_en);
    end
    tick(); flush = 1'b0; settle();
    checks++;
    if (if_to_id_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'h80) begin
      errors++; $display("FAIL flush_redirect: got valid=%b en=%b addr=%h, required 0 1 80", if_to_id_valid, imem_en, imem_addr);
    end
    sb_q.push_back('{pc: 32'h80, inst: mem_word(32'h80), mis: 1'b0});
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_to_id_valid !== 1'b1 || if_pc !== 32'h80) begin
      errors++; $display("FAIL flush_after: got valid=%b pc=%h, required 1 80", if_to_id_valid, if_pc);
    end
    tick();
  endtask

  task automatic test_misaligned();
    tick();
    pre_if_valid = 1'b1; pc_next = 32'h102; id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h102, inst: NOP, mis: 1'b1});
    settle();
    checks++;
    if (imem_en !== 1'b0 || if_allow_in !== 1'b1) begin
      errors++; $display("FAIL misalign_req: got en=%b allow=%b, required 0 1", imem_en, if_allow_in);
    end
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_to_id_valid !== 1'b1 || if_excp_misalign !== 1'b1 || if_inst !== NOP || if_pc !== 32'h102) begin
      errors++; $display("FAIL misalign_out: got valid=%b mis=%b inst=%h pc=%h, required 1 1 00000013 102",
                         if_to_id_valid, if_excp_misalign, if_inst, if_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    tick();
    pre_if_valid = 1'b1; pc_next = 32'h40; id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h40, inst: mem_word(32'h40), mis: 1'b0});
    tick();
    pc_next = 32'h44;
    sb_q.push_back('{pc: 32'h44, inst: mem_word(32'h44), mis: 1'b0});
    settle();
    checks++;
    if (if_pc !== 32'h40 || if_to_id_valid !== 1'b1 || imem_en !== 1'b1) begin
      errors++; $display("FAIL b2b_leave: got pc=%h valid=%b en=%b, required 40 1 1", if_pc, if_to_id_valid, imem_en);
    end
    tick(); pre_if_valid = 1'b0; settle();
    checks++;
    if (if_pc !== 32'h44 || if_to_id_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_next: got pc=%h valid=%b, required 44 1", if_pc, if_to_id_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    tick();
    pre_if_valid = 1'b1; pc_next = 32'h50; id_allow_in = 1'b1;
    sb_q.push_back('{pc: 32'h50, inst: mem_word(32'h50), mis: 1'b0});
    tick(); pre_if_valid = 1'b0; id_allow_in = 1'b0;
    tick();
    rst_n = 1'b0;
    void'(sb_q.pop_front());
    tick(); rst_n = 1'b1; settle();
    checks++;
    if (if_to_id_valid !== 1'b0 || if_allow_in !== 1'b1) begin
      errors++; $display("FAIL reset_mid_stall: got valid=%b allow=%b, required 0 1", if_to_id_valid, if_allow_in);
    end
    tick(); settle();
    checks++;
    if (if_to_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got valid=%b, required 0", if_to_id_valid);
    end
    id_allow_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_hold();
    test_flush();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_stall();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
